// File: rtl/program_loader.sv
// Boot loader: parses a sync/count/words/checksum byte frame into instruction memory, holds the CPU in reset until verified.
// One write cycle per word (rx_ready drops for it); rx_ready is the only combinational output.
module program_loader #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t     state;
  logic [7:0] chk;
  logic [7:0] remaining;
  logic [7:0] hi;
  logic       xfer;

  always_comb begin
    rx_ready = (state != S_WRITE) && (state != S_DONE);
  end

  assign xfer = rx_valid && rx_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      chk        <= 8'h00;
      remaining  <= 8'h00;
      hi         <= 8'h00;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (xfer && rx_data == SYNC) state <= S_LEN;
        end
        S_LEN: begin
          if (xfer) begin
            if (rx_data == 8'h00) begin
              error <= 1'b1;
              state <= S_ERR;
            end else begin
              remaining <= rx_data;
              chk       <= rx_data;
              imem_addr <= '0;
              state     <= S_HI;
            end
          end
        end
        S_HI: begin
          if (xfer) begin
            hi    <= rx_data;
            chk   <= chk ^ rx_data;
            state <= S_LO;
          end
        end
        S_LO: begin
          // The write is issued straight from the low-byte edge so the word lands one cycle later.
          if (xfer) begin
            imem_wdata <= {hi, rx_data};
            imem_we    <= 1'b1;
            chk        <= chk ^ rx_data;
            state      <= S_WRITE;
          end
        end
        S_WRITE: begin
          remaining <= remaining - 8'd1;
          if (remaining == 8'd1) begin
            state <= S_CHK;
          end else begin
            imem_addr <= imem_addr + ADDR_W'(1);
            state     <= S_HI;
          end
        end
        S_CHK: begin
          if (xfer) begin
            if (rx_data == chk) begin
              done      <= 1'b1;
              cpu_reset <= 1'b0;
              state     <= S_DONE;
            end else begin
              error <= 1'b1;
              state <= S_ERR;
            end
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        S_ERR: begin
          // A fresh sync byte restarts a frame; cpu_reset stays asserted throughout.
          if (xfer && rx_data == SYNC) begin
            error <= 1'b0;
            state <= S_LEN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: frame-level reference model checked against the DUT every cycle.
module tb_program_loader;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;

  program_loader #(.ADDR_W(ADDR_W), .WORD_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  // Reference model: byte position within the frame (-1 = hunting for sync).
  int         m_pos;
  int         m_n;
  int         m_words;
  logic [7:0] m_chk;
  logic [7:0] m_hi;
  bit         m_busy;
  bit         m_done;
  bit         m_err;
  logic [7:0] m_addr;
  logic [15:0] m_wdata;

  // Observed memory image and per-scenario counters.
  logic [15:0] dmem [0:255];
  int          wcount = 0;
  int          rdy_low = 0;
  bit          first_seen = 0;
  logic [7:0]  first_addr = 8'h00;

  function automatic void model_reset();
    m_pos = -1; m_n = 0; m_words = 0; m_chk = 8'h00; m_hi = 8'h00;
    m_busy = 0; m_done = 0; m_err = 0; m_addr = 8'h00; m_wdata = 16'h0000;
  endfunction

  function automatic bit model_edge(input bit v, input logic [7:0] d);
    bit acc;
    acc = v && !m_done && !m_busy;
    if (m_busy) begin
      m_busy = 0;
      if (m_words < m_n) m_addr = m_addr + 8'd1;
    end
    if (acc) begin
      if (m_pos < 0) begin
        if (d == 8'hA5) begin m_pos = 0; m_err = 0; end
      end else if (m_pos == 0) begin
        if (d == 8'h00) begin
          m_err = 1; m_pos = -1;
        end else begin
          m_n = int'(d); m_chk = d; m_addr = 8'h00; m_words = 0; m_pos = 1;
        end
      end else if (m_pos <= 2 * m_n) begin
        m_chk = m_chk ^ d;
        if (m_pos % 2 == 1) m_hi = d;
        else begin
          m_wdata = {m_hi, d}; m_busy = 1; m_words++;
        end
        m_pos++;
      end else begin
        if (d == m_chk) m_done = 1; else m_err = 1;
        m_pos = -1;
      end
    end
    return acc;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    cmp("rx_ready",   32'(rx_ready),   32'(!m_done && !m_busy));
    cmp("imem_we",    32'(imem_we),    32'(m_busy));
    cmp("imem_addr",  32'(imem_addr),  32'(m_addr));
    cmp("imem_wdata", 32'(imem_wdata), 32'(m_wdata));
    cmp("cpu_reset",  32'(cpu_reset),  32'(!m_done));
    cmp("done",       32'(done),       32'(m_done));
    cmp("error",      32'(error),      32'(m_err));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      compare_all();
      if (imem_we === 1'b1) begin
        dmem[imem_addr] = imem_wdata;
        wcount++;
        if (!first_seen) begin first_seen = 1; first_addr = imem_addr; end
      end
      if (rx_ready === 1'b0 && done === 1'b0) rdy_low++;
    end
  end

  task automatic idle();
    bit a;
    rx_valid = 1'b0;
    rx_data = 8'($urandom);
    @(posedge clk); a = model_edge(1'b0, rx_data);
    @(negedge clk);
  endtask

  task automatic poke(input logic [7:0] d);
    bit a;
    rx_valid = 1'b1; rx_data = d;
    @(posedge clk); a = model_edge(1'b1, d);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input int gap);
    bit acc;
    for (int i = 0; i < gap; i++) idle();
    rx_valid = 1'b1; rx_data = d; acc = 0;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(posedge clk); acc = model_edge(1'b1, d);
      @(negedge clk);
    end
    if (!acc) begin
      checks++; failures++;
      $display("FAIL send_timeout byte=%0h actual=not_accepted required=accepted", d);
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_q(input logic [7:0] q[$], input int maxgap);
    foreach (q[i]) send(q[i], $urandom_range(0, maxgap));
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0; rx_valid = 1'b0; model_reset();
    #1;
    compare_all();
    @(posedge clk); model_reset();
    @(negedge clk); #2;
    reset = 1'b1;
    wcount = 0; first_seen = 0; rdy_low = 0;
    idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] frame1[$];
    logic [7:0] q[$];
    logic [7:0] ck;
    logic [7:0] g;
    int n;
    bit bad;

    frame1 = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    model_reset();
    @(negedge clk); @(negedge clk);
    cmp("rst_rx_ready", 32'(rx_ready), 32'd1);
    cmp("rst_imem_we", 32'(imem_we), 32'd0);
    cmp("rst_addr", 32'(imem_addr), 32'd0);
    cmp("rst_wdata", 32'(imem_wdata), 32'd0);
    cmp("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    cmp("rst_done", 32'(done), 32'd0);
    cmp("rst_error", 32'(error), 32'd0);
    #2; reset = 1'b1; chk_en = 1;
    idle();

    // Basic two-word frame, then bytes after DONE are ignored.
    send_q(frame1, 2);
    idle();
    cmp("f1_mem0", 32'(dmem[0]), 32'h1234);
    cmp("f1_mem1", 32'(dmem[1]), 32'hABCD);
    cmp("f1_wcount", wcount, 2);
    cmp("f1_done", 32'(done), 32'd1);
    cmp("f1_cpu_reset", 32'(cpu_reset), 32'd0);
    cmp("f1_model_done", 32'(m_done), 32'd1);
    poke(8'hA5); poke(8'h01); poke(8'h00);
    cmp("f1_after_done", 32'(done), 32'd1);

    // Leading garbage is discarded.
    do_reset();
    q = '{8'h00, 8'hFF, 8'h5A};
    send_q(q, 1);
    send_q(frame1, 1);
    idle();
    cmp("g_wcount", wcount, 2);
    cmp("g_done", 32'(done), 32'd1);
    cmp("g_mem1", 32'(dmem[1]), 32'hABCD);

    // Bad checksum, then recovery without reset.
    do_reset();
    q = '{8'hA5, 8'h01, 8'h00, 8'h07, 8'h03};
    send_q(q, 1);
    idle();
    cmp("bad_error", 32'(error), 32'd1);
    cmp("bad_done", 32'(done), 32'd0);
    cmp("bad_cpu_reset", 32'(cpu_reset), 32'd1);
    cmp("bad_wcount", wcount, 1);
    cmp("bad_mem0", 32'(dmem[0]), 32'h0007);
    q = '{8'hA5, 8'h01, 8'h00, 8'h07, 8'h06};
    send_q(q, 1);
    idle();
    cmp("rec_error", 32'(error), 32'd0);
    cmp("rec_done", 32'(done), 32'd1);

    // Zero count is a frame error; following junk is discarded.
    do_reset();
    send(8'hA5, 1);
    send(8'h00, 0);
    cmp("n0_error", 32'(error), 32'd1);
    send(8'h11, 1);
    idle();
    cmp("n0_error_hold", 32'(error), 32'd1);
    cmp("n0_wcount", wcount, 0);

    // Continuous rx_valid: ready drops only on the two write cycles.
    do_reset();
    send_q(frame1, 0);
    idle();
    cmp("cont_rdy_low", rdy_low, 2);
    cmp("cont_done", 32'(done), 32'd1);
    cmp("cont_mem0", 32'(dmem[0]), 32'h1234);

    // Reset mid-frame, then a full frame restarts at address 0.
    do_reset();
    q = '{8'hA5, 8'h02, 8'h12};
    send_q(q, 0);
    do_reset();
    send_q(frame1, 1);
    idle();
    cmp("mid_first_addr", 32'(first_addr), 32'd0);
    cmp("mid_wcount", wcount, 2);
    cmp("mid_done", 32'(done), 32'd1);

    // Randomized frames.
    for (int f = 0; f < 25; f++) begin
      do_reset();
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        send(g, $urandom_range(0, 1));
      end
      n = $urandom_range(1, 6);
      q = '{8'hA5, 8'(n)};
      ck = 8'(n);
      for (int w = 0; w < 2 * n; w++) begin
        g = 8'($urandom);
        q.push_back(g);
        ck = ck ^ g;
      end
      bad = ($urandom_range(0, 3) == 0);
      if (bad) ck = ck ^ 8'($urandom_range(1, 255));
      q.push_back(ck);
      send_q(q, $urandom_range(0, 2));
      idle();
      cmp("rand_done", 32'(done), 32'(!bad));
      cmp("rand_error", 32'(error), 32'(bad));
      cmp("rand_wcount", wcount, n);
    end

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader sitting directly upstream of the 16-bit CPU. It receives a framed byte stream from a host link, assembles 16-bit instruction words and writes them into CPU instruction memory from address 0. It holds the CPU in reset until the checksum verifies, then releases it.

## Interface
- ADDR_W, 8, instruction-memory address width; must be >= 8.
- WORD_W, 16, instruction word width; fixed at 16 and not otherwise supported.

- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_valid  in  1  host byte available.
- rx_data  in  8  host byte.
- rx_ready  out  1  loader can accept a byte; a byte transfers on a rising edge where rx_valid && rx_ready.
- imem_we  out  1  instruction-memory write strobe, one-cycle pulse.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  16  write data.
- cpu_reset  out  1  active-high reset driven to the CPU's reset input.
- done  out  1  program loaded and verified.
- error  out  1  frame error latched.

## Operation
- Frame format: sync 0xA5, count N (1..255 words), N words sent high byte then low byte, then checksum.
- The checksum is the XOR of N and all 2N data bytes. The sync byte is excluded.
- FSM states and transitions:
  - IDLE: accept bytes. 0xA5 -> LEN. Any other byte is discarded.
  - LEN: accept N. N=0 -> ERR. Otherwise load remaining=N, set chk=N, set imem_addr=0, -> HI.
  - HI: accept byte into the high half of the word, XOR it into chk, -> LO.
  - LO: accept byte into the low half of the word, XOR it into chk, -> WRITE.
  - WRITE: imem_we=1 for one cycle, with imem_wdata={hi,lo} at the current imem_addr. Decrement remaining.
    - remaining was 1 -> CHK.
    - Otherwise increment imem_addr -> HI.
  - CHK: accept the checksum byte. Byte == chk -> DONE. Mismatch -> ERR.
  - DONE: done=1, cpu_reset=0, rx_ready=0. Terminal until reset; all further bytes are ignored.
  - ERR: error=1, cpu_reset=1, rx_ready=1. Bytes are discarded, except 0xA5, which clears error and goes to LEN.
- rx_ready=1 in IDLE, LEN, HI, LO, CHK and ERR. rx_ready=0 in WRITE and DONE.
- imem_addr wraps modulo 2^ADDR_W. It cannot overflow when ADDR_W >= 8 because N <= 255.
- imem_wdata holds its last value when imem_we=0.
- Reset values: state=IDLE, rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, done=0, error=0, chk=0, remaining=0.
- Reset asserted mid-frame aborts the frame immediately. Words already written stay in memory; the loader does not clear them. The next frame restarts at address 0.

## Timing
- All outputs are registered except rx_ready, which decodes combinationally from state.
- Low byte accepted at edge t: imem_we=1 during cycle t..t+1. HI is re-entered, or CHK is entered, at edge t+1.
- Per-word throughput: 3 cycles minimum (HI, LO, WRITE).
- Checksum accepted at edge c:
  - Match: done=1 and cpu_reset=0 from edge c onward, so the CPU runs its first cycle after c.
  - Mismatch: error=1 from edge c.
- N=0 accepted at edge t: error=1 from edge t.
- rx_valid held high during WRITE is not consumed. The byte transfers on the first edge after rx_ready returns high.
- cpu_reset deasserts only on the DONE transition. It never glitches low in ERR or mid-frame.
- Async reset forces cpu_reset=1 immediately, without waiting for clk.

## Test plan
- Frame A5 02 12 34 AB CD 42:
  - Writes 0x1234 at address 0 and 0xABCD at address 1, exactly two imem_we pulses.
  - done=1 and cpu_reset=0 after the final byte; error=0.
- Bytes 00 FF 5A, then the frame above -> the leading bytes are ignored, with the same writes and done=1.
- Frame A5 01 00 07 03 (bad checksum; correct is 06):
  - Result: error=1, done=0, cpu_reset=1, one write of 0x0007 at address 0.
  - Then A5 01 00 07 06 -> error=0, done=1.
- Bytes A5 00 -> error=1 on the next edge, no imem_we. A following 0x11 is discarded and error stays 1.
- rx_valid held high continuously during the 2-word frame -> rx_ready is low exactly on the 2 WRITE cycles, and all bytes are captured in order with the correct writes.
- After A5 02 12, pulse reset low for 1 cycle -> all outputs return to their reset values. The full frame from the first scenario then writes address 0 first and finishes with done=1.
